// File: rtl/mips_mc_pkg.sv
// Shared encodings for the MIPS multicycle control unit: FSM states, opcodes,
// funct codes, ALUOp/ALUControl values and mux select encodings.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        BNEEX   = 4'd12
    } stateT;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluOpT;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALURESULT = 2'b00;
    localparam logic [1:0] PC_ALUOUT    = 2'b01;
    localparam logic [1:0] PC_JUMP      = 2'b10;

endpackage

// File: rtl/mips_mc_aludec.sv
// ALU decoder: maps the FSM's ALUOp and the instruction funct field to the
// 3-bit ALU operation code.
module mips_mc_aludec
    import mips_mc_pkg::*;
(
    input  logic [1:0] aluOp,
    input  logic [5:0] funct,
    output logic [2:0] aluControl
);

    // Unknown funct codes fall back to add so an odd R-type behaves like a harmless add.
    always_comb begin
        aluControl = ALU_ADD;
        case (aluOp)
            ALUOP_SUB: aluControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: aluControl = ALU_ADD;
                    FUNCT_SUB: aluControl = ALU_SUB;
                    FUNCT_AND: aluControl = ALU_AND;
                    FUNCT_OR:  aluControl = ALU_OR;
                    FUNCT_SLT: aluControl = ALU_SLT;
                    default:   aluControl = ALU_ADD;
                endcase
            end
            default: aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Moore control FSM for the MIPS multicycle CPU. Optional bne support is
// enabled by defining MIPS_MC_BNE_EN.
module mips_mc_controller
    import mips_mc_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       IllegalOp,
    output logic [3:0] State
);

    stateT stateReg, stateNext, decodeState;
    aluOpT aluOp;
    logic  irWriteRaw, memWriteRaw, regWriteRaw, illegalRaw, pcWrite, branch;
`ifdef MIPS_MC_BNE_EN
    logic  branchNe;
`endif

    always_ff @(posedge CLK) begin
        if (Reset) stateReg <= FETCH;
        else       stateReg <= stateNext;
    end

    // During reset the outputs are decoded as if in FETCH, so the datapath sees benign selects.
    assign decodeState = Reset ? FETCH : stateReg;

    always_comb begin
        stateNext   = FETCH;
        aluOp       = ALUOP_ADD;
        irWriteRaw  = 1'b0;
        memWriteRaw = 1'b0;
        regWriteRaw = 1'b0;
        illegalRaw  = 1'b0;
        pcWrite     = 1'b0;
        branch      = 1'b0;
`ifdef MIPS_MC_BNE_EN
        branchNe    = 1'b0;
`endif
        IorD        = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        PCSrc       = PC_ALURESULT;
        case (decodeState)
            FETCH: begin
                irWriteRaw = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                pcWrite    = 1'b1;
                stateNext  = DECODE;
            end
            DECODE: begin
                ALUSrcB = SRCB_IMMSH;
                case (Op)
                    OP_LW, OP_SW: stateNext = MEMADR;
                    OP_RTYPE:     stateNext = RTYPEEX;
                    OP_BEQ:       stateNext = BEQEX;
                    OP_ADDI:      stateNext = ADDIEX;
                    OP_J:         stateNext = JEX;
`ifdef MIPS_MC_BNE_EN
                    OP_BNE:       stateNext = BNEEX;
`endif
                    default: begin
                        stateNext  = FETCH;
                        illegalRaw = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                stateNext = (Op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                IorD      = 1'b1;
                stateNext = MEMWB;
            end
            MEMWB: begin
                MemtoReg    = 1'b1;
                regWriteRaw = 1'b1;
            end
            MEMWR: begin
                IorD        = 1'b1;
                memWriteRaw = 1'b1;
            end
            RTYPEEX: begin
                ALUSrcA   = 1'b1;
                aluOp     = ALUOP_FUNCT;
                stateNext = RTYPEWB;
            end
            RTYPEWB: begin
                RegDst      = 1'b1;
                regWriteRaw = 1'b1;
            end
            BEQEX: begin
                ALUSrcA = 1'b1;
                aluOp   = ALUOP_SUB;
                PCSrc   = PC_ALUOUT;
                branch  = 1'b1;
            end
`ifdef MIPS_MC_BNE_EN
            BNEEX: begin
                ALUSrcA  = 1'b1;
                aluOp    = ALUOP_SUB;
                PCSrc    = PC_ALUOUT;
                branchNe = 1'b1;
            end
`endif
            ADDIEX: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                stateNext = ADDIWB;
            end
            ADDIWB: regWriteRaw = 1'b1;
            JEX: begin
                PCSrc   = PC_JUMP;
                pcWrite = 1'b1;
            end
            default: stateNext = FETCH;
        endcase
    end

    mips_mc_aludec aluDec (
        .aluOp      (aluOp),
        .funct      (Funct),
        .aluControl (ALUControl)
    );

    assign MemWrite  = memWriteRaw & ~Reset;
    assign IRWrite   = irWriteRaw & ~Reset;
    assign RegWrite  = regWriteRaw & ~Reset;
    assign IllegalOp = illegalRaw & ~Reset;
`ifdef MIPS_MC_BNE_EN
    assign PCEn = ~Reset & (pcWrite | (branch & Zero) | (branchNe & ~Zero));
`else
    assign PCEn = ~Reset & (pcWrite | (branch & Zero));
`endif
    assign State = stateReg;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller: directed instructions, a mid-store
// reset abort, then a random instruction stream against a per-instruction model.
module tb_mips_mc_controller;

    typedef int stateQ[$];

    logic       CLK;
    logic       Reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] PCSrc;
    logic       PCEn, IllegalOp;
    logic [3:0] State;

    int passCount = 0;
    int failCount = 0;
    int checkCount = 0;

    mips_mc_controller dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Op         (Op),
        .Funct      (Funct),
        .Zero       (Zero),
        .MemWrite   (MemWrite),
        .IorD       (IorD),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .PCSrc      (PCSrc),
        .PCEn       (PCEn),
        .IllegalOp  (IllegalOp),
        .State      (State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit bneEnabled();
`ifdef MIPS_MC_BNE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit isLegal(input logic [5:0] op);
        return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
               op == 6'b000100 || op == 6'b001000 || op == 6'b000010 ||
               (op == 6'b000101 && bneEnabled());
    endfunction

    // Visited state codes for one whole instruction, starting at FETCH.
    function automatic stateQ expectedStates(input logic [5:0] op);
        stateQ q;
        case (op)
            6'b100011: q = '{0, 1, 2, 3, 4};
            6'b101011: q = '{0, 1, 2, 5};
            6'b000000: q = '{0, 1, 6, 7};
            6'b000100: q = '{0, 1, 8};
            6'b001000: q = '{0, 1, 9, 10};
            6'b000010: q = '{0, 1, 11};
            6'b000101: if (bneEnabled()) q = '{0, 1, 12}; else q = '{0, 1};
            default:   q = '{0, 1};
        endcase
        return q;
    endfunction

    function automatic logic [2:0] aluForFunct(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_memwrite"}, 8'(MemWrite), 8'd0);
        checkOutput({tag, "_irwrite"}, 8'(IRWrite), 8'd0);
        checkOutput({tag, "_regwrite"}, 8'(RegWrite), 8'd0);
        checkOutput({tag, "_pcen"}, 8'(PCEn), 8'd0);
        checkOutput({tag, "_illegal"}, 8'(IllegalOp), 8'd0);
        checkOutput({tag, "_iord"}, 8'(IorD), 8'd0);
        checkOutput({tag, "_srcb"}, 8'(ALUSrcB), 8'd1);
        checkOutput({tag, "_aluctl"}, 8'(ALUControl), 8'd2);
    endtask

    // zeroMode: 0/1 forces Zero, 2 randomizes it each cycle. abortAt >= 0 raises Reset in that cycle.
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct,
                                 input int zeroMode, input int abortAt);
        stateQ seq;
        int    lastK;
        bit    isLw, isSw, isR, isBeq, isBne, isAddi, isJ, illegal;
        logic  expPcEn;
        logic [1:0] expSrcB, expPcSrc;
        logic [2:0] expAlu;
        string tag;
        seq    = expectedStates(op);
        lastK  = seq.size() - 1;
        isLw   = (op == 6'b100011);
        isSw   = (op == 6'b101011);
        isR    = (op == 6'b000000);
        isBeq  = (op == 6'b000100);
        isBne  = (op == 6'b000101) && bneEnabled();
        isAddi = (op == 6'b001000);
        isJ    = (op == 6'b000010);
        illegal = !isLegal(op);
        Op    = op;
        Funct = funct;
        for (int k = 0; k <= lastK; k++) begin
            Zero = (zeroMode == 2) ? 1'($urandom_range(0, 1)) : (zeroMode == 1);
            @(negedge CLK);
            tag = $sformatf("op%b_k%0d", op, k);

            expPcEn = (k == 0);
            if (k == 2 && isJ) expPcEn = 1'b1;
            if (k == 2 && isBeq) expPcEn = Zero;
            if (k == 2 && isBne) expPcEn = ~Zero;

            expSrcB = 2'b00;
            if (k == 0) expSrcB = 2'b01;
            if (k == 1) expSrcB = 2'b11;
            if (k == 2 && (isLw || isSw || isAddi)) expSrcB = 2'b10;

            expAlu = 3'b010;
            if (k == 2 && isR) expAlu = aluForFunct(funct);
            if (k == 2 && (isBeq || isBne)) expAlu = 3'b110;

            expPcSrc = 2'b00;
            if (k == 2 && (isBeq || isBne)) expPcSrc = 2'b01;
            if (k == 2 && isJ) expPcSrc = 2'b10;

            checkOutput({tag, "_state"}, 8'(State), 8'(seq[k]));
            checkOutput({tag, "_irwrite"}, 8'(IRWrite), 8'(k == 0));
            checkOutput({tag, "_pcen"}, 8'(PCEn), 8'(expPcEn));
            checkOutput({tag, "_regwrite"}, 8'(RegWrite),
                        8'(k == lastK && k >= 3 && (isLw || isR || isAddi)));
            checkOutput({tag, "_memtoreg"}, 8'(MemtoReg), 8'(isLw && k == 4));
            checkOutput({tag, "_regdst"}, 8'(RegDst), 8'(isR && k == 3));
            checkOutput({tag, "_memwrite"}, 8'(MemWrite), 8'(isSw && k == 3));
            checkOutput({tag, "_iord"}, 8'(IorD), 8'((isLw || isSw) && k == 3));
            checkOutput({tag, "_illegal"}, 8'(IllegalOp), 8'(illegal && k == 1));
            checkOutput({tag, "_srca"}, 8'(ALUSrcA), 8'(k == 2 && !isJ && !illegal));
            checkOutput({tag, "_srcb"}, 8'(ALUSrcB), 8'(expSrcB));
            checkOutput({tag, "_aluctl"}, 8'(ALUControl), 8'(expAlu));
            checkOutput({tag, "_pcsrc"}, 8'(PCSrc), 8'(expPcSrc));

            if (k == abortAt) begin
                Reset = 1'b1;
                #1;
                checkOutput("abort_state_held", 8'(State), 8'(seq[k]));
                checkResetOutputs("abort_comb");
                for (int c = 0; c < 3; c++) begin
                    @(posedge CLK);
                    #1;
                    checkOutput($sformatf("abort_state_c%0d", c), 8'(State), 8'd0);
                    checkResetOutputs($sformatf("abort_c%0d", c));
                end
                Reset = 1'b0;
                return;
            end
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        logic [5:0] op, funct;
        int pick;
        $display("[TB] starting mips_mc_controller bench");
        Reset = 1'b1;
        Op    = 6'b101011;
        Funct = 6'b000000;
        Zero  = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset_state", 8'(State), 8'd0);
        checkResetOutputs("reset");
        @(posedge CLK);
        #1;
        Reset = 1'b0;

        applyStimulus(6'b100011, 6'b000000, 2, -1);
        applyStimulus(6'b000000, 6'b100010, 2, -1);
        applyStimulus(6'b000100, 6'b000000, 1, -1);
        applyStimulus(6'b000100, 6'b000000, 0, -1);
        applyStimulus(6'b000010, 6'b000000, 2, -1);
        applyStimulus(6'b000101, 6'b000000, 0, -1);
        applyStimulus(6'b000101, 6'b000000, 1, -1);
        applyStimulus(6'b111111, 6'b000000, 2, -1);
        applyStimulus(6'b001000, 6'b000000, 2, -1);
        applyStimulus(6'b101011, 6'b000000, 2, 3);
        applyStimulus(6'b000000, 6'b101010, 2, -1);
        applyStimulus(6'b101011, 6'b000000, 2, -1);

        for (int n = 0; n < 60; n++) begin
            pick = int'($urandom_range(0, 9));
            funct = 6'($urandom_range(0, 63));
            case (pick)
                0: op = 6'b100011;
                1: op = 6'b101011;
                2, 3: begin
                    op = 6'b000000;
                    case ($urandom_range(0, 5))
                        0: funct = 6'b100000;
                        1: funct = 6'b100010;
                        2: funct = 6'b100100;
                        3: funct = 6'b100101;
                        4: funct = 6'b101010;
                        default: ;
                    endcase
                end
                4: op = 6'b000100;
                5: op = 6'b001000;
                6: op = 6'b000010;
                7: op = 6'b000101;
                default: begin
                    op = 6'b111111;
                    for (int t = 0; t < 20; t++) begin
                        op = 6'($urandom_range(0, 63));
                        if (!isLegal(op)) break;
                    end
                    if (isLegal(op)) op = 6'b111111;
                end
            endcase
            applyStimulus(op, funct, 2, (n % 17 == 5) ? int'(expectedStates(op).size()) - 1 : -1);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
